// File: rtl/agu_pkg.sv
// Shared types and helpers for the agu_stream nested-loop address generator.
// Default widths here match the agu_stream parameter defaults.
package agu_pkg;

  localparam int unsigned AGU_BWADDR   = 21;
  localparam int unsigned AGU_BWLENGTH = 8;
  localparam int unsigned AGU_BWREP    = 16;
  localparam int unsigned AGU_NJUMPS   = 5;
  localparam int unsigned AGU_OH_W     = 32;

  typedef enum logic {AGU_IDLE, AGU_RUN} agu_state_e;

  typedef logic [AGU_BWADDR-1:0]   agu_addr_t;
  typedef logic [AGU_BWLENGTH-1:0] agu_len_t;
  typedef logic [AGU_BWREP-1:0]    agu_rep_t;

  // zero[k] flags level k (1..n-1) as exhausted; result is one-hot on the deepest
  // non-exhausted level, or bit 0 (pass wrap) when every level is exhausted.
  function automatic logic [AGU_OH_W-1:0] agu_jump_level(input logic [AGU_OH_W-1:0] zero,
                                                         input int unsigned n);
    logic [AGU_OH_W-1:0] oh;
    oh    = '0;
    oh[0] = 1'b1;
    for (int unsigned k = 1; k < n; k++) begin
      if (!zero[k]) begin
        oh    = '0;
        oh[k] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/agu_loop_cnt.sv
// Per-level loop down-counter: load wins over decrement; zero flag marks the level exhausted.
module agu_loop_cnt #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [BW-1:0] load_val_i,
  output logic          zero_o
);

  logic [BW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - BW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/agu_stream.sv
// N-level nested-loop address generator with valid/ready output stream.
// Optional offset windowing is enabled by defining AGU_WRAP_EN (adds win_size_i).
module agu_stream
  import agu_pkg::*;
#(
  parameter int unsigned BWADDR   = AGU_BWADDR,
  parameter int unsigned BWLENGTH = AGU_BWLENGTH,
  parameter int unsigned BWREP    = AGU_BWREP,
  parameter int unsigned NJUMPS   = AGU_NJUMPS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_i,
  input  logic                                start_i,
  input  logic [BWADDR-1:0]                   base_i,
  input  logic [BWREP-1:0]                    reps_i,
  input  logic [NJUMPS-1:0][BWADDR-1:0]       j_i,
  input  logic [NJUMPS-1:1][BWLENGTH-1:0]     l_i,
`ifdef AGU_WRAP_EN
  input  logic [BWADDR-1:0]                   win_size_i,
`endif
  output logic                                busy_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [BWADDR-1:0]                   addr_o,
  output logic [NJUMPS-1:0]                   on_j_o,
  output logic                                last_o,
  output logic                                done_o
);

  agu_state_e                       state_q;
  logic [BWADDR-1:0]                base_q, offset_q, addr_q;
  logic [BWADDR-1:0]                jump_c, off_sum_c, off_nxt_c;
  logic [BWREP-1:0]                 reps_q, pass_q;
  logic [NJUMPS-1:0][BWADDR-1:0]    j_q;
  logic [NJUMPS-1:1][BWLENGTH-1:0]  l_q;
  logic                             busy_q, valid_q, done_q;
  logic [NJUMPS-1:1]                lvl_zero;
  logic [AGU_OH_W-1:0]              zero_v, oh_full;
  logic [NJUMPS-1:0]                oh;
  logic                             all_zero, last_c, acc, start_c, unused_oh;
`ifdef AGU_WRAP_EN
  logic [BWADDR-1:0]                win_q;
`endif

  assign start_c  = (state_q == AGU_IDLE) & start_i & ~clr_i;
  assign acc      = valid_q & ready_i;
  assign all_zero = &lvl_zero;

  always_comb begin
    zero_v = '1;
    for (int unsigned k = 1; k < NJUMPS; k++) zero_v[k] = lvl_zero[k];
  end

  assign oh_full   = agu_jump_level(zero_v, NJUMPS);
  assign oh        = oh_full[NJUMPS-1:0];
  assign unused_oh = |(oh_full >> NJUMPS);

  assign last_c = valid_q & all_zero & (reps_q != '0) & (pass_q == reps_q);
  assign on_j_o = (valid_q & ~last_c) ? oh : '0;
  assign last_o = last_c;

  always_comb begin
    jump_c = '0;
    for (int unsigned k = 0; k < NJUMPS; k++) begin
      if (oh[k]) jump_c = jump_c | j_q[k];
    end
  end

  assign off_sum_c = offset_q + jump_c;

`ifdef AGU_WRAP_EN
  // Sum lies in (-win, 2*win): a single add or subtract brings it back into the window.
  always_comb begin
    off_nxt_c = off_sum_c;
    if (win_q != '0) begin
      if (off_sum_c[BWADDR-1])      off_nxt_c = off_sum_c + win_q;
      else if (off_sum_c >= win_q)  off_nxt_c = off_sum_c - win_q;
    end
  end
`else
  assign off_nxt_c = off_sum_c;
`endif

  // A level reloads whenever a shallower level (or the pass wrap) takes the jump.
  for (genvar m = 1; m < NJUMPS; m++) begin : g_lvl
    logic                load, dec;
    logic [BWLENGTH-1:0] load_val;

    assign dec      = acc & oh[m];
    assign load     = start_c | (acc & ~last_c & (|oh[m-1:0]));
    assign load_val = (state_q == AGU_IDLE) ? l_i[m] : l_q[m];

    agu_loop_cnt #(.BW(BWLENGTH)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .dec_i      (dec),
      .load_val_i (load_val),
      .zero_o     (lvl_zero[m])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AGU_IDLE;
      base_q   <= '0;
      offset_q <= '0;
      addr_q   <= '0;
      reps_q   <= '0;
      pass_q   <= '0;
      j_q      <= '0;
      l_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef AGU_WRAP_EN
      win_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        state_q <= AGU_IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          AGU_IDLE: begin
            if (start_i) begin
              state_q  <= AGU_RUN;
              base_q   <= base_i;
              reps_q   <= reps_i;
              j_q      <= j_i;
              l_q      <= l_i;
              offset_q <= '0;
              pass_q   <= BWREP'(1);
              addr_q   <= base_i;
              busy_q   <= 1'b1;
              valid_q  <= 1'b1;
`ifdef AGU_WRAP_EN
              win_q    <= win_size_i;
`endif
            end
          end
          AGU_RUN: begin
            if (acc) begin
              if (last_c) begin
                state_q <= AGU_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                offset_q <= off_nxt_c;
                addr_q   <= base_q + off_nxt_c;
                if (all_zero && reps_q != '0) pass_q <= pass_q + BWREP'(1);
              end
            end
          end
          default: state_q <= AGU_IDLE;
        endcase
      end
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign done_o  = done_q;

endmodule
